// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a ready/valid input.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// then STOP_BITS stop bits. Every bit lasts CLK_FREQ/BAUD clocks, truncated.
module uart_tx_param #(
    parameter int CLK_FREQ  = 32'sd50_000_000,
    parameter int BAUD      = 32'sd9600,
    parameter int DATA_BITS = 32'sd8,
    parameter int PARITY    = 32'sd0,
    parameter int STOP_BITS = 32'sd1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(BAUD_DIV - 32'sd1);
    localparam logic [CW-1:0] BAUD_ONE   = CW'(1'b1);
    localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 32'sd1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 32'sd1);
    localparam logic          HAS_PARITY = (PARITY != 32'sd0);
    localparam logic          ODD_PARITY = (PARITY == 32'sd1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic f_parity_bit(input logic [DATA_BITS-1:0] d);
        logic even;
        even = ^d;
        return ODD_PARITY ? ~even : even;
    endfunction

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_baud_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_tx_done;
    logic                   w_tick;
    logic                   w_accept;

    assign w_tick   = (r_baud_cnt == BAUD_LAST);
    assign w_accept = in_valid && (r_state == S_IDLE);

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;
    assign tx_done  = r_tx_done;

    // State register; reset returns to IDLE and discards any frame in flight.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave IDLE on accept, otherwise advance one bit per baud tick.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_START;
                else          w_state_next = S_IDLE;
            end
            S_START: begin
                if (w_tick) w_state_next = S_DATA;
                else        w_state_next = S_START;
            end
            S_DATA: begin
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
                    if (HAS_PARITY) w_state_next = S_PARITY;
                    else            w_state_next = S_STOP;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_next = S_STOP;
                else        w_state_next = S_PARITY;
            end
            S_STOP: begin
                if (w_tick && (r_bit_cnt == STOP_LAST)) w_state_next = S_IDLE;
                else                                    w_state_next = S_STOP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Baud counter: free-runs 0..BAUD_DIV-1 while busy, held at 0 in IDLE.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
        end
    end

    // Datapath: latch word and parity on accept, drive the line bit by bit.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 4'd0;
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_par   <= f_parity_bit(in_data);
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= 4'd0;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= 4'd0;
                            r_tx      <= HAS_PARITY ? r_par : 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_cnt <= 4'd0;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= 4'd0;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= 4'd0;
                    r_tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule
